// File: rtl/mux_rr_arbiter8_pkg.sv
// Shared widths and state encoding for the round-robin select arbiter.
package mux_rr_arbiter8_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_arbiter8_rr_pick8.sv
// Rotate-priority encoder: first set request at or after start, optionally skipping one index.
module rr_pick8
  import mux_rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  input  logic [SEL_W-1:0] mask_idx,
  input  logic             use_mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (req[cand] && !(use_mask && (cand == mask_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter8.sv
// Round-robin arbiter driving the select of a shared 8:1 4-bit mux, with bounded hold time.
module mux_rr_arbiter8
  import mux_rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             active
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_e            state_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [N_REQ-1:0]  grant_q;
  logic [SEL_W-1:0]  sel_q;
  logic              active_q;

  logic [SEL_W-1:0]  pick_start_c;
  logic              pick_mask_c;
  logic              pick_found_c;
  logic [SEL_W-1:0]  pick_idx_c;
  logic              own_req_c;
  logic              new_grant_c;
  logic              go_idle_c;

  // When owned, search starts after the owner and skips it; the skip is
  // harmless on release because the owner's request is low then.
  assign pick_start_c = (state_q == ST_IDLE) ? ptr_q : sel_q + SEL_W'(1);
  assign pick_mask_c  = (state_q == ST_OWNED);
  assign own_req_c    = req[sel_q];

  rr_pick8 u_pick (
    .req      (req),
    .start    (pick_start_c),
    .mask_idx (sel_q),
    .use_mask (pick_mask_c),
    .found    (pick_found_c),
    .idx      (pick_idx_c)
  );

  assign new_grant_c = pick_found_c &&
                       ((state_q == ST_IDLE) || !own_req_c || (hold_q == HOLD_MAX));
  assign go_idle_c   = (state_q == ST_OWNED) && !own_req_c && !pick_found_c;

  // State, pointer, hold counter and registered outputs; sel is kept while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      active_q <= 1'b0;
    end else if (new_grant_c) begin
      state_q  <= ST_OWNED;
      ptr_q    <= pick_idx_c + SEL_W'(1);
      hold_q   <= HOLD_W'(1);
      grant_q  <= N_REQ'(1) << pick_idx_c;
      sel_q    <= pick_idx_c;
      active_q <= 1'b1;
    end else if (go_idle_c) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      grant_q  <= '0;
      active_q <= 1'b0;
    end else if ((state_q == ST_OWNED) && (hold_q < HOLD_MAX)) begin
      hold_q   <= hold_q + HOLD_W'(1);
    end
  end

  assign grant  = grant_q;
  assign sel    = sel_q;
  assign active = active_q;

endmodule
